sigmoid_pool: RTL and testbench

Streaming pooling stage directly downstream of the `sigmoid` pipeline. It consumes one 16-bit sigmoid result per valid cycle and groups consecutive valid samples into fixed-size windows. For each completed window it emits the truncated mean and the maximum. It also keeps a wrapping window counter and reports its own transistor count on `number`, matching the rest of the datapath.

---
 rtl/sigmoid_pool.sv | 100 ++++++++++
 tb/tb_sigmoid_pool.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sigmoid_pool.sv
// Streaming pooling stage behind the sigmoid pipeline. It groups consecutive valid samples
// into windows of 2^GROUP_LOG2 and emits the floor mean, the maximum and a wrapping window index.
module sigmoid_pool #(
    parameter int GROUP_LOG2 = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] i_y,
    input  logic        i_in_valid,
    output logic        o_out_valid,
    output logic [15:0] o_avg,
    output logic [15:0] o_max,
    output logic [7:0]  o_grp,
    output logic [50:0] number
);

    localparam int N  = 1 << GROUP_LOG2;
    localparam int AW = 16 + GROUP_LOG2;
    localparam logic [GROUP_LOG2-1:0] CNT_LAST = GROUP_LOG2'(N - 1);

    // Per-cell transistor costs (static CMOS): full adder, half adder, 2:1 mux, reset flop.
    localparam longint T_FA   = 28;
    localparam longint T_HA   = 14;
    localparam longint T_MUX2 = 12;
    localparam longint T_DFFR = 26;

    localparam longint N_FF   = longint'(AW + 16 + GROUP_LOG2 + 8 + 16 + 16 + 8 + 1);
    localparam longint N_FA   = longint'(AW + 16);
    localparam longint N_HA   = longint'(GROUP_LOG2 + 8);
    localparam longint N_MUX  = longint'(2 * AW + 3 * 16 + 2 * GROUP_LOG2 + 8 + 16 + 16 + 8);
    localparam longint NUM_T  = N_FF * T_DFFR + N_FA * T_FA + N_HA * T_HA + N_MUX * T_MUX2;

    logic [AW-1:0]         acc_q, acc_d, acc_sum;
    logic [15:0]           mx_q, mx_d, mx_cand;
    logic [GROUP_LOG2-1:0] cnt_q, cnt_d;
    logic [7:0]            grp_q, grp_d;
    logic [15:0]           avg_q, avg_d;
    logic [15:0]           max_q, max_d;
    logic [7:0]            ogrp_q, ogrp_d;
    logic                  valid_q, valid_d;
    logic                  first, close;

    assign acc_sum = acc_q + AW'(i_y);
    assign mx_cand = (i_y > mx_q) ? i_y : mx_q;
    assign first   = (cnt_q == '0);
    assign close   = i_in_valid && (cnt_q == CNT_LAST);

    // The first sample of a window loads acc/mx directly, so back-to-back windows lose no cycle.
    always_comb begin
        acc_d   = acc_q;
        mx_d    = mx_q;
        cnt_d   = cnt_q;
        grp_d   = grp_q;
        avg_d   = avg_q;
        max_d   = max_q;
        ogrp_d  = ogrp_q;
        valid_d = 1'b0;
        if (i_in_valid) begin
            acc_d = first ? AW'(i_y) : acc_sum;
            mx_d  = first ? i_y : mx_cand;
            cnt_d = close ? '0 : cnt_q + GROUP_LOG2'(1);
            if (close) begin
                avg_d   = acc_sum[AW-1:GROUP_LOG2];
                max_d   = mx_cand;
                ogrp_d  = grp_q;
                grp_d   = grp_q + 8'd1;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            mx_q    <= '0;
            cnt_q   <= '0;
            grp_q   <= '0;
            avg_q   <= '0;
            max_q   <= '0;
            ogrp_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            mx_q    <= mx_d;
            cnt_q   <= cnt_d;
            grp_q   <= grp_d;
            avg_q   <= avg_d;
            max_q   <= max_d;
            ogrp_q  <= ogrp_d;
            valid_q <= valid_d;
        end
    end

    assign o_out_valid = valid_q;
    assign o_avg       = avg_q;
    assign o_max       = max_q;
    assign o_grp       = ogrp_q;
    assign number      = 51'(NUM_T);

endmodule

// File: tb/tb_sigmoid_pool.sv
// Directed bench for sigmoid_pool (GROUP_LOG2=2): ramp, saturation, bubbles, mid-window reset,
// group-index wrap and hand-computed golden groups.
module tb_sigmoid_pool;

  logic        clk;
  logic        rst_n;
  logic [15:0] i_y;
  logic        i_in_valid;
  logic        o_out_valid;
  logic [15:0] o_avg;
  logic [15:0] o_max;
  logic [7:0]  o_grp;
  logic [50:0] number;

  int tests_run;
  int tests_failed;
  logic [50:0] number_ref;

  sigmoid_pool #(.GROUP_LOG2(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_y        (i_y),
    .i_in_valid (i_in_valid),
    .o_out_valid(o_out_valid),
    .o_avg      (o_avg),
    .o_max      (o_max),
    .o_grp      (o_grp),
    .number     (number)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one input for one edge; outputs are then observed 1 time unit after that edge.
  task automatic cyc(input logic v, input logic [15:0] y);
    i_in_valid = v;
    i_y        = y;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name);
    tests_run++;
    if (o_out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s: o_out_valid=%0b expected 0", name, o_out_valid);
    end
  endtask

  task automatic check_pulse(input string name, input logic [15:0] avg, input logic [15:0] mx,
                             input logic [7:0] grp);
    tests_run++;
    if (o_out_valid !== 1'b1 || o_avg !== avg || o_max !== mx || o_grp !== grp) begin
      tests_failed++;
      $display("FAIL %s: valid=%0b avg=%h max=%h grp=%0d expected valid=1 avg=%h max=%h grp=%0d",
               name, o_out_valid, o_avg, o_max, o_grp, avg, mx, grp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_in_valid = 1'b0;
    i_y = '0;
    #12;
    tests_run++;
    if (o_out_valid !== 1'b0 || o_avg !== 16'h0 || o_max !== 16'h0 || o_grp !== 8'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: valid=%0b avg=%h max=%h grp=%0d expected all 0",
               o_out_valid, o_avg, o_max, o_grp);
    end
    number_ref = number;
    tests_run++;
    if (number === '0 || $isunknown(number)) begin
      tests_failed++;
      $display("FAIL number_nonzero: number=%0d expected nonzero", number);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_ramp();
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 16'(i));
      if (i == 3) check_pulse("ramp_w0", 16'd1, 16'd3, 8'd0);
      else if (i == 7) check_pulse("ramp_w1", 16'd5, 16'd7, 8'd1);
      else check_idle("ramp_idle");
    end
    cyc(1'b0, 16'h0);
    check_idle("ramp_after");
    tests_run++;
    if (o_avg !== 16'd5 || o_max !== 16'd7 || o_grp !== 8'd1) begin
      tests_failed++;
      $display("FAIL ramp_hold: avg=%h max=%h grp=%0d expected 5 7 1", o_avg, o_max, o_grp);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 16'hFFFF);
      if (i == 3) check_pulse("saturation", 16'hFFFF, 16'hFFFF, 8'd2);
      else check_idle("saturation_idle");
    end
  endtask

  task automatic test_bubbles();
    cyc(1'b1, 16'h8000); check_idle("bubble_s0");
    cyc(1'b0, 16'h1111); check_idle("bubble_gap0");
    cyc(1'b1, 16'h4000); check_idle("bubble_s1");
    cyc(1'b0, 16'h2222); check_idle("bubble_gap1");
    cyc(1'b0, 16'h3333); check_idle("bubble_gap2");
    cyc(1'b1, 16'h0000); check_idle("bubble_s2");
    cyc(1'b1, 16'h0004); check_pulse("bubbles", 16'h3001, 16'h8000, 8'd3);
    cyc(1'b0, 16'h0);    check_idle("bubble_after");
  endtask

  task automatic test_mid_reset();
    cyc(1'b1, 16'h0100);
    cyc(1'b1, 16'h0200);
    cyc(1'b1, 16'h0300);
    i_in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (o_out_valid !== 1'b0 || o_avg !== 16'h0 || o_max !== 16'h0 || o_grp !== 8'h0) begin
      tests_failed++;
      $display("FAIL async_reset: valid=%0b avg=%h max=%h grp=%0d expected all 0",
               o_out_valid, o_avg, o_max, o_grp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 16'h0010);
      if (i == 3) check_pulse("mid_reset", 16'h0010, 16'h0010, 8'd0);
      else check_idle("mid_reset_idle");
    end
  endtask

  task automatic test_wrap();
    logic [15:0] base;
    // Group k of this run carries samples 4k..4k+3: floor mean 4k+1, max 4k+3.
    for (int k = 0; k < 257; k++) begin
      for (int j = 0; j < 4; j++) begin
        cyc(1'b1, 16'(4 * k + j));
        if (j == 3) begin
          base = 16'(4 * k);
          check_pulse("wrap", base + 16'd1, base + 16'd3, 8'((k + 1) % 256));
        end else if (j == 0 && k > 0) begin
          check_idle("wrap_spacing");
        end
      end
    end
  endtask

  task automatic test_golden();
    logic [15:0] vec [0:11];
    logic [15:0] exp_avg [0:2];
    logic [15:0] exp_max [0:2];
    vec = '{16'h1234, 16'h0001, 16'hFFFF, 16'h8000,
            16'h0007, 16'h0007, 16'h0007, 16'h0008,
            16'h0000, 16'h0000, 16'h0000, 16'h0003};
    exp_avg = '{16'h648D, 16'h0007, 16'h0000};
    exp_max = '{16'hFFFF, 16'h0008, 16'h0003};
    // Wrap run left the group counter at 258 mod 256 = 2.
    for (int g = 0; g < 3; g++) begin
      for (int j = 0; j < 4; j++) begin
        cyc(1'b1, vec[g * 4 + j]);
        if (j == 3) check_pulse("golden", exp_avg[g], exp_max[g], 8'(2 + g));
      end
    end
    tests_run++;
    if (number !== number_ref) begin
      tests_failed++;
      $display("FAIL number_const: number=%0d expected %0d", number, number_ref);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_ramp();
    test_saturation();
    test_bubbles();
    test_mid_reset();
    test_wrap();
    test_golden();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
